wb_arbiter2: RTL and testbench
==============================

// Module: wb_arbiter2
// PURPOSE
//  Two-master, one-slave Wishbone classic arbiter for the 23-bit-address / 8-bit-data bus.
//  Shares the slave bus between m0 (UART bridge) and m1 (on-chip engine) with round-robin grant.
//  Adds a watchdog that ends a hung cycle with err to the master when the slave never terminates.
// PARAMETERS
//  ADDR_W        23   address width
//  DATA_W        8    data width
//  TIMEOUT_CYC   255  stb cycles without ack/err/rty before abort; 0 disables the watchdog
// PORTS
//  clk_i        in   1       clock; all state on rising edge
//  rst_i        in   1       synchronous reset, active-high
//  m0_cyc_i, m0_stb_i, m0_we_i   in  1 each   master 0 cycle, strobe, write enable
//  m0_adr_i     in   ADDR_W  master 0 address
//  m0_dat_i     in   DATA_W  master 0 write data
//  m0_dat_o     out  DATA_W  read data to master 0
//  m0_ack_o, m0_err_o, m0_rty_o  out 1 each   cycle termination to master 0
//  m1_*         (same set as m0_*)            master 1
//  s_cyc_o, s_stb_o, s_we_o      out 1 each   slave cycle, strobe, write enable
//  s_adr_o      out  ADDR_W  slave address
//  s_dat_o      out  DATA_W  slave write data
//  s_dat_i      in   DATA_W  slave read data
//  s_ack_i, s_err_i, s_rty_i     in  1 each   slave termination
//  gnt_o        out  2       one-hot grant {m1,m0}; 2'b00 when idle or aborting
// BEHAVIOUR
//  State register: IDLE, GNT0, GNT1, ABORT. Reset -> IDLE, rr_last <= 1 (m0 favoured), wdog <= 0.
//  Reset state of outputs: s_cyc_o = s_stb_o = 0; every m*_ack/err/rty = 0; gnt_o = 0.
//  IDLE: if exactly one mX_cyc_i is high, go to GNTX. If both are high, grant the master not equal
//   to rr_last. The grant is registered, so the earliest s_cyc_o is the cycle after the master's cyc.
//  GNTX: the slave outputs are a combinational mux of master X (cyc, stb, we, adr, dat).
//   s_ack/err/rty and s_dat_i route to master X only; the other master sees 0 on its term outputs.
//   mX_dat_o = s_dat_i when granted, else 0.
//  GNTX exit: when mX_cyc_i = 0 go to IDLE, set rr_last <= X and clear wdog. There is one dead cycle
//   before the next grant. Back-to-back requests from both masters therefore alternate.
//  Watchdog: wdog increments each cycle s_stb_o = 1 and no slave ack/err/rty.
//   It clears on any slave termination and on leaving GNTX. It saturates and never wraps.
//   When wdog == TIMEOUT_CYC - 1 and no termination occurs that cycle: assert mX_err_o for exactly
//   that cycle, ignore the slave, and go to ABORT.
//  A slave termination arriving in the same cycle as the timeout wins: it is forwarded and there is
//   no abort.
//  ABORT: s_cyc_o = s_stb_o = 0 and no term to either master. Stay until the aborted master drops
//   cyc, then go to IDLE with rr_last <= aborted master.
//  Master drops cyc with no termination: the grant is released normally; no err is produced.
//  Master holds cyc and deasserts stb between beats: the grant is held, wdog pauses (no count).
//  Reset mid-transfer: the next edge forces IDLE. s_cyc_o falls in that cycle and no term is emitted.
//  Widths: wdog is $clog2(TIMEOUT_CYC+1) bits. adr and data pass through unmodified.
// STRUCTURE
//  Shared package wb_pkg:
//   - WB_ADDR_W = 23 and WB_DATA_W = 8
//   - arb_state_t enum {IDLE, GNT0, GNT1, ABORT}
//   - a wb_req_t struct {cyc, stb, we, adr, dat} for the mux
//  Sub-module wb_watchdog (count, clear, saturate, expire pulse) is natural and reusable.
//  The arbiter FSM and the mux stay in wb_arbiter2.
// TESTING
//  Single m0 read: cyc at T0 -> s_cyc_o at T1 with m0 adr; slave ack with 8'hA5 at T3 ->
//   m0_ack_o = 1 and m0_dat_o = 8'hA5 at T3; m1 term outputs stay 0.
//  Simultaneous cyc from reset -> m0 granted first (gnt_o = 01). After m0 releases: one idle
//   cycle, then gnt_o = 10. Repeated contention alternates 01, 10, 01.
//  Hung slave, TIMEOUT_CYC = 4 -> m0_err_o pulses on the 4th stb cycle and s_cyc_o drops the
//   same cycle. FSM holds ABORT until m0 drops cyc, then IDLE.
//  Slave ack in the expiry cycle -> ack forwarded, no err, no ABORT.
//  Reset asserted during an m1 write -> next cycle s_cyc_o = 0, gnt_o = 0. After reset, m0 wins
//   a simultaneous request.
//  Master holds cyc with stb low for 10 cycles (TIMEOUT_CYC = 4) -> no err and the grant is
//   held. A later stb + ack completes normally.

Source files
------------

// File: rtl/wb_pkg.sv
// +--------------------------------------------------------------------------+
// | wb_pkg : shared widths, arbiter state encoding and request bundle for the |
// |          23-bit-address / 8-bit-data Wishbone classic bus                 |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package wb_pkg;

  localparam int WB_ADDR_W = 23;
  localparam int WB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [WB_ADDR_W-1:0] adr;
    logic [WB_DATA_W-1:0] dat;
  } wb_req_t;

  function automatic wb_req_t wb_req_mux(input logic sel1, input wb_req_t r0, input wb_req_t r1);
    return sel1 ? r1 : r0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_watchdog.sv
// +--------------------------------------------------------------------------+
// | wb_watchdog : saturating stall counter with a one-cycle expire pulse;     |
// |               TIMEOUT_CYC = 0 disables expiry                             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_count,
  input  logic i_clear,
  output logic o_expire
);

  localparam int              WD_W   = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic            c_EN   = (TIMEOUT_CYC > 0);
  localparam logic [WD_W-1:0] c_LAST = WD_W'((TIMEOUT_CYC < 1) ? 0 : TIMEOUT_CYC - 1);
  localparam logic [WD_W-1:0] c_MAX  = {WD_W{1'b1}};

  logic [WD_W-1:0] r_wdog;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wdog <= '0;
    end else if (i_count && (r_wdog != c_MAX)) begin
      r_wdog <= r_wdog + WD_W'(1);
    end
  end

  // Fires on the stalled cycle that would bring the count to TIMEOUT_CYC.
  assign o_expire = c_EN && i_count && (r_wdog == c_LAST);

endmodule

`default_nettype wire

// File: rtl/wb_arbiter2.sv
// +--------------------------------------------------------------------------+
// | wb_arbiter2 : two-master / one-slave Wishbone classic round-robin arbiter |
// |               with a watchdog that aborts hung slave cycles with err      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int ADDR_W      = WB_ADDR_W,
  parameter int DATA_W      = WB_DATA_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_rty_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_rty_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  output logic [1:0]        gnt_o
);

  arb_state_t r_state;
  logic       r_rr_last;
  logic       r_abort_m;

  wb_req_t w_req0;
  wb_req_t w_req1;
  wb_req_t w_sel;
  logic    w_g0;
  logic    w_g1;
  logic    w_granted;
  logic    w_term;
  logic    w_live_stb;
  logic    w_release;
  logic    w_expire;

  assign w_req0 = '{cyc: m0_cyc_i, stb: m0_stb_i, we: m0_we_i, adr: m0_adr_i, dat: m0_dat_i};
  assign w_req1 = '{cyc: m1_cyc_i, stb: m1_stb_i, we: m1_we_i, adr: m1_adr_i, dat: m1_dat_i};

  assign w_g0      = (r_state == GNT0);
  assign w_g1      = (r_state == GNT1);
  assign w_granted = w_g0 | w_g1;
  assign w_sel     = wb_req_mux(w_g1, w_req0, w_req1);
  assign w_term    = s_ack_i | s_err_i | s_rty_i;
  assign w_live_stb = w_granted & w_sel.cyc & w_sel.stb;
  assign w_release = w_granted & ~w_sel.cyc;

  wb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk      (clk_i),
    .rst      (rst_i),
    .i_count  (w_live_stb & ~w_term),
    .i_clear  (w_term | ~w_granted | w_release),
    .o_expire (w_expire)
  );

  // On expiry the slave is cut off in the same cycle the err pulse goes out.
  assign s_cyc_o = w_granted & w_sel.cyc & ~w_expire;
  assign s_stb_o = w_live_stb & ~w_expire;
  assign s_we_o  = w_granted & w_sel.we;
  assign s_adr_o = w_sel.adr;
  assign s_dat_o = w_sel.dat;

  assign m0_ack_o = w_g0 & s_ack_i;
  assign m0_rty_o = w_g0 & s_rty_i;
  assign m0_err_o = w_g0 & (s_err_i | w_expire);
  assign m0_dat_o = w_g0 ? s_dat_i : '0;

  assign m1_ack_o = w_g1 & s_ack_i;
  assign m1_rty_o = w_g1 & s_rty_i;
  assign m1_err_o = w_g1 & (s_err_i | w_expire);
  assign m1_dat_o = w_g1 ? s_dat_i : '0;

  assign gnt_o = {w_g1, w_g0};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_rr_last <= 1'b1;
      r_abort_m <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            r_state <= r_rr_last ? GNT0 : GNT1;
          end else if (m0_cyc_i) begin
            r_state <= GNT0;
          end else if (m1_cyc_i) begin
            r_state <= GNT1;
          end
        end
        GNT0, GNT1: begin
          if (w_release) begin
            r_state   <= IDLE;
            r_rr_last <= w_g1;
          end else if (w_expire) begin
            r_state   <= ABORT;
            r_abort_m <= w_g1;
          end
        end
        ABORT: begin
          if (!(r_abort_m ? m1_cyc_i : m0_cyc_i)) begin
            r_state   <= IDLE;
            r_rr_last <= r_abort_m;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter2.sv
// +--------------------------------------------------------------------------+
// | tb_wb_arbiter2 : directed self-checking bench for wb_arbiter2             |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [22:0] m0_adr, m1_adr, s_adr;
  logic [7:0]  m0_dat_w, m1_dat_w, m0_dat_r, m1_dat_r, s_dat_w, s_dat_r;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic        s_cyc, s_stb, s_we, s_ack, s_err, s_rty;
  logic [1:0]  gnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.ADDR_W(23), .DATA_W(8), .TIMEOUT_CYC(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_dat_w), .m0_dat_o(m0_dat_r),
    .m0_ack_o(m0_ack), .m0_err_o(m0_err), .m0_rty_o(m0_rty),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_dat_w), .m1_dat_o(m1_dat_r),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rty_o(m1_rty),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_dat_w), .s_dat_i(s_dat_r),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty),
    .gnt_o(gnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; checks follow 1 time unit later.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_w = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_w = '0;
    s_dat_r = '0; s_ack = 0; s_err = 0; s_rty = 0;

    // Reset state
    nxt(); nxt(); #1;
    chk("rst_s_cyc", 32'(s_cyc), 0);
    chk("rst_s_stb", 32'(s_stb), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_terms", 32'({m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}), 0);
    nxt(); rst = 1'b0;

    // Single m0 read
    nxt(); m0_cyc = 1; m0_stb = 1; m0_adr = 23'h12345; #1;
    chk("rd_T0_s_cyc", 32'(s_cyc), 0);
    nxt(); #1;
    chk("rd_T1_s_cyc", 32'(s_cyc), 1);
    chk("rd_T1_gnt", 32'(gnt), 32'h1);
    chk("rd_T1_adr", 32'(s_adr), 32'h12345);
    nxt();
    nxt(); s_ack = 1; s_dat_r = 8'hA5; #1;
    chk("rd_T3_m0_ack", 32'(m0_ack), 1);
    chk("rd_T3_m0_dat", 32'(m0_dat_r), 32'hA5);
    chk("rd_T3_m1_terms", 32'({m1_ack, m1_err, m1_rty}), 0);
    chk("rd_T3_m1_dat", 32'(m1_dat_r), 0);
    nxt(); s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
    chk("rd_rel_s_cyc", 32'(s_cyc), 0);
    nxt(); #1;
    chk("rd_idle_gnt", 32'(gnt), 0);

    // Hung slave: err on 4th stb cycle, then ABORT until m0 drops cyc
    nxt(); m0_cyc = 1; m0_stb = 1; m0_adr = 23'h00010;
    nxt(); nxt(); nxt();
    nxt(); #1;
    chk("hang_m0_err", 32'(m0_err), 1);
    chk("hang_s_cyc", 32'(s_cyc), 0);
    chk("hang_m1_err", 32'(m1_err), 0);
    nxt(); #1;
    chk("abort_gnt", 32'(gnt), 0);
    chk("abort_m0_err", 32'(m0_err), 0);
    nxt(); #1;
    chk("abort_hold_gnt", 32'(gnt), 0);
    chk("abort_hold_s_cyc", 32'(s_cyc), 0);
    nxt(); m0_cyc = 0; m0_stb = 0;
    nxt(); m1_cyc = 1; m1_stb = 1;
    nxt(); #1;
    chk("abort_exit_gnt", 32'(gnt), 32'h2);
    nxt(); m1_cyc = 0; m1_stb = 0;
    nxt();

    // Slave ack in the expiry cycle wins
    nxt(); m0_cyc = 1; m0_stb = 1;
    nxt(); nxt(); nxt();
    nxt(); s_ack = 1; #1;
    chk("race_m0_ack", 32'(m0_ack), 1);
    chk("race_m0_err", 32'(m0_err), 0);
    chk("race_s_cyc", 32'(s_cyc), 1);
    nxt(); s_ack = 0; m0_cyc = 0; m0_stb = 0; #1;
    chk("race_no_abort_gnt", 32'(gnt), 32'h1);
    nxt();

    // cyc held with stb low: watchdog paused, grant held
    nxt(); m0_cyc = 1; m0_stb = 0;
    for (int i = 0; i < 10; i++) begin
      nxt(); #1;
      chk("hold_gnt", 32'(gnt), 32'h1);
      chk("hold_m0_err", 32'(m0_err), 0);
    end
    nxt(); m0_stb = 1;
    nxt();
    nxt(); s_ack = 1; #1;
    chk("hold_ack", 32'(m0_ack), 1);
    chk("hold_ack_err", 32'(m0_err), 0);
    nxt(); s_ack = 0; m0_cyc = 0; m0_stb = 0;
    nxt();

    // m1 write interrupted by reset
    nxt(); m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 23'h7FFFFF; m1_dat_w = 8'h3C;
    nxt(); #1;
    chk("wr_gnt", 32'(gnt), 32'h2);
    chk("wr_s_we", 32'(s_we), 1);
    chk("wr_s_adr", 32'(s_adr), 32'h7FFFFF);
    chk("wr_s_dat", 32'(s_dat_w), 32'h3C);
    nxt(); rst = 1;
    nxt(); rst = 0; m0_cyc = 1; m0_stb = 1; m1_we = 0; #1;
    chk("rst_mid_s_cyc", 32'(s_cyc), 0);
    chk("rst_mid_gnt", 32'(gnt), 0);

    // Contention after reset alternates 01, 10, 01 with one dead cycle between
    nxt(); #1;
    chk("rr_first", 32'(gnt), 32'h1);
    nxt(); m0_cyc = 0; m0_stb = 0; #1;
    chk("rr_m0_rel", 32'(gnt), 32'h1);
    nxt(); #1;
    chk("rr_dead1", 32'(gnt), 0);
    nxt(); m0_cyc = 1; m0_stb = 1; #1;
    chk("rr_second", 32'(gnt), 32'h2);
    nxt(); m1_cyc = 0; m1_stb = 0; #1;
    chk("rr_m1_rel", 32'(gnt), 32'h2);
    nxt(); #1;
    chk("rr_dead2", 32'(gnt), 0);
    nxt(); #1;
    chk("rr_third", 32'(gnt), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
